// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
//
// Turns the raw PS/2 scan-byte stream into key events. The block decodes the
// E0 (extended) and F0 (break) prefixes, optionally drops typematic repeats of
// the key that is currently held, and queues the events in a FIFO. The FIFO is
// read by a valid/ready consumer.
//
// Parameters
//   DEPTH            event FIFO depth (power of 2, >= 2)
//   SUPPRESS_REPEAT  1: a make event for the key already held is dropped
//
// Ports
//   clk           clock
//   resetn        synchronous, active-low reset
//   rx_valid      one-cycle pulse, rx_byte holds a frame-checked byte
//   rx_byte       received scan byte
//   rx_err        one-cycle pulse, frame/parity error (beats rx_valid)
//   evt_valid     FIFO head holds an event
//   evt_ready     consumer accepts the head event
//   evt_code      scan code of the head event
//   evt_ext       head event had the E0 prefix
//   evt_break     head event is a release
//   held_valid    a key is currently held
//   held_code     {ext,code} of the last accepted make
//   press_count   accepted make events, wraps modulo 256
//   fifo_level    number of stored events, 0..DEPTH
//   overflow      sticky, an event was dropped on a full FIFO
//   clr_overflow  clears overflow (a same-edge set wins)

module ps2_key_sequencer #(
  parameter int DEPTH           = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_err,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_break,
  output logic                     held_valid,
  output logic [8:0]               held_code,
  output logic [7:0]               press_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] S_E0   = 2'd1;
  localparam logic [1:0] S_F0   = 2'd2;
  localparam logic [1:0] S_E0F0 = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          dec_make;
  logic          dec_break;
  logic          dec_ext;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [8:0]    key;
  logic          repeat_hit;
  logic          accept_make;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  // Prefix decoder. A complete event is recognised on the same edge that
  // samples its final byte; prefixes only move the state. An error frame
  // abandons any partial sequence.
  always_comb begin
    state_nxt = state;
    dec_make  = 1'b0;
    dec_break = 1'b0;
    dec_ext   = 1'b0;
    if (rx_err) begin
      state_nxt = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hE0) begin
            state_nxt = S_E0;
          end else if (rx_byte == 8'hF0) begin
            state_nxt = S_F0;
          end else if (rx_byte == 8'hAA || rx_byte == 8'hFA || rx_byte == 8'hFE ||
                       rx_byte == 8'h00 || rx_byte == 8'hFF) begin
            // Keyboard status/ack bytes carry no key information.
            state_nxt = IDLE;
          end else begin
            dec_make = 1'b1;
          end
        end
        S_E0: begin
          if (rx_byte == 8'hF0) begin
            state_nxt = S_E0F0;
          end else begin
            dec_make  = 1'b1;
            dec_ext   = 1'b1;
            state_nxt = IDLE;
          end
        end
        S_F0: begin
          // F0 followed by E0 is out of order; the sequence is discarded.
          if (rx_byte != 8'hE0) begin
            dec_break = 1'b1;
          end
          state_nxt = IDLE;
        end
        default: begin
          dec_break = 1'b1;
          dec_ext   = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Repeat filter and FIFO handshake. A full FIFO still accepts a push when
  // the head is popped on the same edge, so only a push without a pop drops.
  always_comb begin
    key         = {dec_ext, rx_byte};
    repeat_hit  = SUPPRESS_REPEAT && held_valid && (key == held_code);
    accept_make = dec_make & ~repeat_hit;
    push        = dec_break | accept_make;
    pop         = evt_valid & evt_ready;
    full        = (fifo_level == LVL_FULL);
    wr_en       = push & (~full | pop);
    drop        = push & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      held_valid  <= 1'b0;
      held_code   <= 9'd0;
      press_count <= 8'd0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !pop) begin
        fifo_level <= fifo_level + (AW+1)'(1);
      end else if (pop && !wr_en) begin
        fifo_level <= fifo_level - (AW+1)'(1);
      end

      // Held-key tracking is independent of whether the FIFO had room.
      if (accept_make) begin
        press_count <= press_count + 8'd1;
        held_code   <= key;
        held_valid  <= 1'b1;
      end else if (dec_break && key == held_code) begin
        held_valid <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Event storage needs no reset; its contents are only visible while valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {dec_ext, dec_break, rx_byte};
    end
  end

  assign evt_valid = (fifo_level != '0);
  assign evt_ext   = mem[rd_ptr][9];
  assign evt_break = mem[rd_ptr][8];
  assign evt_code  = mem[rd_ptr][7:0];

endmodule
